// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared state, size codes and opcode layout for the load/store sequencer
package ls_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_ILLEGAL = 2'b00;
    localparam logic [1:0] SZ_BYTE    = 2'b01;
    localparam logic [1:0] SZ_HALF    = 2'b10;
    localparam logic [1:0] SZ_WORD    = 2'b11;

    localparam int OP_STORE_BIT = 2;
    localparam int OP_SIZE_HI   = 1;
    localparam int OP_SIZE_LO   = 0;

    // Illegal size or an access not aligned to its own size.
    function automatic logic op_bad(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_ILLEGAL)
            || (size == SZ_HALF && lane[0])
            || (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/ls_lane_unit.sv
// rtl/ls_lane_unit.sv - little-endian byte/half lane merge and extract
module ls_lane_unit
    import ls_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [15:0] wsrc,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        merged    = rdata;
        extracted = rdata;
        bsel      = rdata[{lane, 3'b000} +: 8];
        hsel      = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wsrc[7:0];
                extracted = {{24{sign_ext & bsel[7]}}, bsel};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wsrc;
                extracted = {{16{sign_ext & hsel[15]}}, hsel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// rtl/load_store_sequencer.sv - single-request load/store FSM with read-modify-write for sub-word stores
module load_store_sequencer
    import ls_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        is_store_r, sext_r, err_r;
    logic [1:0]  size_r, lane_r;
    logic [15:0] sdata_r;
    logic [31:0] merged, extracted;

    logic [1:0] size_in;
    logic       store_in, bad_in;

    assign size_in  = op[OP_SIZE_HI:OP_SIZE_LO];
    assign store_in = op[OP_STORE_BIT];
    assign bad_in   = op_bad(size_in, addr[1:0]);

    ls_lane_unit u_lane (
        .size      (size_r),
        .sign_ext  (sext_r),
        .lane      (lane_r),
        .rdata     (mem_rdata),
        .wsrc      (sdata_r),
        .merged    (merged),
        .extracted (extracted)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad_in)
                        state_nx = S_DONE;
                    else if (store_in && size_in == SZ_WORD)
                        state_nx = S_WRITE;
                    else
                        state_nx = S_READ;
                end
            end
            S_READ:  state_nx = S_WAIT;
            S_WAIT:  if (cnt == 3'd0) state_nx = is_store_r ? S_WRITE : S_DONE;
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs below are pure state decodes; data outputs come from registers.
    assign busy   = (state != S_IDLE);
    assign mem_wr = (state == S_WRITE);
    assign done   = (state == S_DONE);
    assign err    = done & err_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            is_store_r <= 1'b0;
            sext_r     <= 1'b0;
            err_r      <= 1'b0;
            size_r     <= SZ_ILLEGAL;
            lane_r     <= 2'b00;
            sdata_r    <= 16'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            load_data  <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_store_r <= store_in;
                        size_r     <= size_in;
                        sext_r     <= sign_ext;
                        lane_r     <= addr[1:0];
                        sdata_r    <= store_data[15:0];
                        err_r      <= bad_in;
                        mem_addr   <= {addr[31:2], 2'b00};
                        if (store_in && size_in == SZ_WORD)
                            mem_wdata <= store_data;
                    end
                end
                S_READ: cnt <= 3'(MEM_LAT - 1);
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        if (is_store_r)
                            mem_wdata <= merged;
                        else
                            load_data <= extracted;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// tb/tb_load_store_sequencer.sv - directed bench for two latency variants against a transaction-level model
module tb_load_store_sequencer;

    logic        clock = 1'b0;
    logic        reset, start, sign_ext;
    logic [2:0]  op;
    logic [31:0] addr, store_data, mem_rdata;

    logic [31:0] mem_addr_o[2], mem_wdata_o[2], load_data_o[2];
    logic        mem_wr_o[2], busy_o[2], done_o[2], err_o[2];

    always #5 clock = ~clock;

    load_store_sequencer #(.MEM_LAT(1)) u_lat1 (
        .clock(clock), .reset(reset), .start(start), .op(op), .sign_ext(sign_ext),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr_o[0]), .mem_wr(mem_wr_o[0]), .mem_wdata(mem_wdata_o[0]),
        .load_data(load_data_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    load_store_sequencer #(.MEM_LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .start(start), .op(op), .sign_ext(sign_ext),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr_o[1]), .mem_wr(mem_wr_o[1]), .mem_wdata(mem_wdata_o[1]),
        .load_data(load_data_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: per instance, cycles since start, total latency and write cycle.
    int          lat[2] = '{1, 3};
    bit          m_act[2], m_err[2], m_load[2];
    int          m_k[2], m_len[2], m_wcyc[2];
    logic [31:0] m_addr[2], m_wdata[2], m_ld[2], m_ldnew[2];

    always @(posedge clock) begin : model
        int nbytes, sh;
        logic [31:0] low, mask, v;
        logic [1:0] sz;
        bit st, badop, was_idle;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0;
                m_ld[i]  = 32'd0;
            end else begin
                was_idle = !m_act[i];
                if (m_act[i]) begin
                    if (m_k[i] == m_len[i]) m_act[i] = 0;
                    else begin
                        m_k[i]++;
                        if (m_k[i] == m_len[i] && m_load[i] && !m_err[i]) m_ld[i] = m_ldnew[i];
                    end
                end
                if (was_idle && start) begin
                    sz = op[1:0];
                    st = op[2];
                    badop = (sz == 2'd0) || (sz == 2'd2 && addr[0]) || (sz == 2'd3 && addr[1:0] != 2'd0);
                    nbytes = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
                    sh = 8 * (int'(addr[1:0]) & ~(nbytes - 1));
                    low = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
                    mask = low << sh;
                    v = (mem_rdata >> sh) & low;
                    if (sign_ext && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~low;
                    m_act[i]   = 1;
                    m_k[i]     = 1;
                    m_err[i]   = badop;
                    m_load[i]  = !st;
                    m_addr[i]  = {addr[31:2], 2'b00};
                    m_ldnew[i] = v;
                    m_wdata[i] = (st && sz == 2'd3) ? store_data
                               : ((mem_rdata & ~mask) | ((store_data << sh) & mask));
                    if (badop) begin
                        m_len[i] = 1;  m_wcyc[i] = -1;
                    end else if (st && sz == 2'd3) begin
                        m_len[i] = 2;  m_wcyc[i] = 1;
                    end else if (st) begin
                        m_len[i] = lat[i] + 3;  m_wcyc[i] = lat[i] + 2;
                    end else begin
                        m_len[i] = lat[i] + 2;  m_wcyc[i] = -1;
                    end
                end
            end
        end
    end

    int          wr_cnt[2], wr_cyc[2], done_cnt[2], done_cyc[2];
    logic [31:0] wr_data[2], wr_addr[2];
    logic        done_err[2];

    always @(negedge clock) begin : compare
        bit eb, ew, ed;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                eb = m_act[i];
                ew = m_act[i] && (m_k[i] == m_wcyc[i]);
                ed = m_act[i] && (m_k[i] == m_len[i]);
                chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(eb));
                chk($sformatf("mem_wr[%0d]", i), 32'(mem_wr_o[i]), 32'(ew));
                chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(ed));
                chk($sformatf("load_data[%0d]", i), load_data_o[i], m_ld[i]);
                if (ed) chk($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(m_err[i]));
                if (m_act[i] && !m_err[i]) chk($sformatf("mem_addr[%0d]", i), mem_addr_o[i], m_addr[i]);
                if (ew) chk($sformatf("mem_wdata[%0d]", i), mem_wdata_o[i], m_wdata[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (mem_wr_o[i]) begin
                wr_cnt[i]++;
                wr_cyc[i]  = cyc - c0;
                wr_data[i] = mem_wdata_o[i];
                wr_addr[i] = mem_addr_o[i];
            end
            if (done_o[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc - c0;
                done_err[i] = err_o[i];
            end
        end
    end

    task automatic go(input logic [2:0] o, input logic se, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] rd, input int hold);
        @(negedge clock);
        op = o; sign_ext = se; addr = a; store_data = sd; mem_rdata = rd;
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; done_cnt[i] = 0; wr_cyc[i] = -1; done_cyc[i] = -1;
        end
        repeat (hold) @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; sign_ext = 1'b0;
        addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_addr", mem_addr_o[i], 32'd0);
            chk("rst_mem_wdata", mem_wdata_o[i], 32'd0);
            chk("rst_load_data", load_data_o[i], 32'd0);
            chk("rst_flags", {28'd0, mem_wr_o[i], busy_o[i], done_o[i], err_o[i]}, 32'd0);
        end
        reset = 1'b0;
        chk_on = 1;

        // SB 0x103: top byte replaced, done at MEM_LAT+3
        go(3'b101, 1'b0, 32'h103, 32'h0000_00AB, 32'h1122_3344, 1);
        repeat (10) @(negedge clock);
        chk("sb_wr_cnt", 32'(wr_cnt[0]), 32'd1);
        chk("sb_wdata", wr_data[0], 32'hAB22_3344);
        chk("sb_addr", wr_addr[0], 32'h100);
        chk("sb_done_cyc", 32'(done_cyc[0]), 32'd4);
        chk("sb_done_cyc_lat3", 32'(done_cyc[1]), 32'd6);

        // LH 0x202 sign/zero extended
        go(3'b010, 1'b1, 32'h202, 32'd0, 32'h8001_FFFF, 1);
        repeat (8) @(negedge clock);
        chk("lh_sext", load_data_o[0], 32'hFFFF_8001);
        chk("lh_done_cyc", 32'(done_cyc[0]), 32'd3);
        go(3'b010, 1'b0, 32'h202, 32'd0, 32'h8001_FFFF, 1);
        repeat (8) @(negedge clock);
        chk("lh_zext", load_data_o[1], 32'h0000_8001);
        chk("lh_err", 32'(done_err[1]), 32'd0);

        // SW: no read phase
        go(3'b111, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h5555_5555, 1);
        repeat (6) @(negedge clock);
        chk("sw_wr_cyc", 32'(wr_cyc[1]), 32'd1);
        chk("sw_done_cyc", 32'(done_cyc[1]), 32'd2);
        chk("sw_wdata", wr_data[1], 32'hDEAD_BEEF);

        // LW misaligned
        go(3'b011, 1'b0, 32'h6, 32'd0, 32'h1234_5678, 1);
        repeat (6) @(negedge clock);
        chk("lw_mis_done_cyc", 32'(done_cyc[0]), 32'd1);
        chk("lw_mis_err", 32'(done_err[0]), 32'd1);
        chk("lw_mis_wr", 32'(wr_cnt[0] + wr_cnt[1]), 32'd0);
        chk("lw_mis_ld", load_data_o[0], 32'h0000_8001);

        // More lane patterns, checked by the model
        go(3'b001, 1'b1, 32'h21, 32'd0, 32'h1234_8056, 1);
        repeat (8) @(negedge clock);
        chk("lb_sext", load_data_o[0], 32'hFFFF_FF80);
        go(3'b001, 1'b0, 32'h23, 32'd0, 32'h9A34_8056, 1);
        repeat (8) @(negedge clock);
        chk("lb_zext", load_data_o[1], 32'h0000_009A);
        go(3'b011, 1'b1, 32'h44, 32'd0, 32'hCAFE_F00D, 1);
        repeat (8) @(negedge clock);
        chk("lw", load_data_o[0], 32'hCAFE_F00D);
        go(3'b110, 1'b0, 32'h2, 32'hFFFF_5566, 32'hAAAA_BBBB, 1);
        repeat (10) @(negedge clock);
        chk("sh_wdata", wr_data[1], 32'h5566_BBBB);
        go(3'b100, 1'b0, 32'h0, 32'h1, 32'h0, 1);
        repeat (4) @(negedge clock);
        chk("illegal_err", 32'(done_err[1]), 32'd1);
        go(3'b110, 1'b0, 32'h1, 32'h1, 32'h0, 1);
        repeat (4) @(negedge clock);
        chk("sh_mis_wr", 32'(wr_cnt[0] + wr_cnt[1]), 32'd0);

        // SH with reset during WAIT
        go(3'b110, 1'b0, 32'h0, 32'h1234, 32'h0, 1);
        repeat (1) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        chk("rst_wait_busy", 32'(busy_o[1]), 32'd0);
        chk("rst_wait_wr", 32'(wr_cnt[0] + wr_cnt[1]), 32'd0);
        chk("rst_wait_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
        chk("rst_wait_ld", load_data_o[0], 32'd0);

        // SB again, start held through the MEM_LAT=3 transaction
        go(3'b101, 1'b0, 32'h103, 32'h0000_00AB, 32'h1122_3344, 6);
        repeat (12) @(negedge clock);
        chk("hold_wr_cnt", 32'(wr_cnt[1]), 32'd1);
        chk("hold_done_cnt", 32'(done_cnt[1]), 32'd1);
        chk("hold_done_cyc", 32'(done_cyc[1]), 32'd6);
        chk("hold_wdata", wr_data[1], 32'hAB22_3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_sequencer.md
LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning memory read latency in cycles (legal 1..7).
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request pulse, sampled only in IDLE.
REQ-005 op  input  3  {is_store, size[1:0]}; size 01=byte, 10=half, 11=word, 00=illegal.
REQ-006 sign_ext  input  1  loads: 1 sign-extends byte/half, 0 zero-extends.
REQ-007 addr  input  32  byte address.
REQ-008 store_data  input  32  store source; byte in [7:0], half in [15:0].
REQ-009 mem_rdata  input  32  memory read word.
REQ-010 mem_addr  output  32  word-aligned memory address ({addr[31:2],2'b00}).
REQ-011 mem_wr  output  1  memory write strobe, one cycle.
REQ-012 mem_wdata  output  32  merged write word.
REQ-013 load_data  output  32  extracted/extended load result, held until next done.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  valid with done; misaligned or illegal op.

Function
REQ-017 States SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-018 IDLE + start SHALL latch op, sign_ext, addr, store_data; unlatched inputs are ignored while busy.
REQ-019 Illegal size, half with addr[0]=1, or word with addr[1:0]!=0 SHALL go IDLE->DONE with err=1, no mem_wr, load_data unchanged.
REQ-020 Word store SHALL go IDLE->WRITE->DONE without reading memory; mem_wdata=store_data.
REQ-021 Loads and byte/half stores SHALL go IDLE->READ->WAIT; WAIT SHALL last MEM_LAT cycles via down-counter, then capture mem_rdata.
REQ-022 After WAIT, loads SHALL go to DONE; byte/half stores SHALL go to WRITE.
REQ-023 Lane select little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; half j = bits [16j+15:16j], j=addr[1].
REQ-024 Store merge SHALL replace only the addressed lane of the captured word; other lanes unchanged.
REQ-025 Load extract SHALL right-justify the lane and extend per latched sign_ext; word loads pass unmodified.
REQ-026 mem_wr SHALL be high exactly in WRITE; mem_addr SHALL be stable from READ through WRITE.
REQ-027 done SHALL be high exactly one cycle in DONE; DONE->IDLE unconditionally; a start in DONE is ignored.
REQ-028 Latency (start to done): word store 2, load MEM_LAT+2, byte/half store MEM_LAT+3, error 1.

Reset
REQ-029 reset SHALL override all activity, including mid-operation, next edge: state IDLE, counter 0.
REQ-030 Reset values: mem_addr 0, mem_wr 0, mem_wdata 0, load_data 0, busy 0, done 0, err 0.
REQ-031 Reset during WRITE SHALL deassert mem_wr the following cycle; no further write issued.

Structure
REQ-032 Package ls_pkg SHALL hold state enum, size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and opcode field positions.
REQ-033 Combinational sub-module ls_lane_unit SHALL implement merge and extract; sequencer holds FSM and registers.
REQ-034 Outputs SHALL be registered or decoded from state only; no combinational path from mem_rdata to outputs.

Verification
REQ-035 SB addr=0x103, store_data=0xAB, memory word 0x11223344 -> one mem_wr, mem_addr=0x100, mem_wdata=0xAB223344, done at MEM_LAT+3.
REQ-036 LH addr=0x202, sign_ext=1, mem word 0x8001FFFF -> load_data=0xFFFF8001; sign_ext=0 -> 0x00008001, err=0.
REQ-037 SW addr=0x10, data=0xDEADBEEF -> no read phase, mem_wr in cycle 1, done cycle 2.
REQ-038 LW addr=0x6 -> done with err=1 after 1 cycle, mem_wr never asserted, load_data unchanged.
REQ-039 SH addr=0x0 with reset asserted during WAIT -> state IDLE, busy=0, no mem_wr, no done.
REQ-040 Repeat REQ-035 with MEM_LAT=3 and start held high during busy -> only one transaction, correct latency.
